timer_unit: RTL and testbench
=============================

# timer_unit

Memory-mapped 32-bit countdown timer on the processor's data-memory bus, selected by the system bridge from `m_data_addr`/`m_data_wdata`/`m_data_byteen`. Its interrupt output drives one bit of the processor's `HWInt[5:0]`. It provides three word registers (CTRL, PRESET, COUNT) and a four-state counting FSM. It supports one-shot mode (0) and auto-reload mode (1).

## Interface
- `PRESET_RST`, 32'h0, reset value of PRESET

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `sel`  in  1  chip select from the bridge; writes are ignored when low
- `addr`  in  2  word offset (`m_data_addr[3:2]`): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved
- `we`  in  1  write strobe, qualified by `sel`
- `byteen`  in  4  per-byte write enables; bit i writes `wdata[8i+7:8i]`
- `wdata`  in  32  write data
- `rdata`  out  32  combinational read of the register at `addr`, independent of `sel`; reserved reads 0
- `irq`  out  1  interrupt request, equal to `CTRL.IM & irq_flag`

## Operation
- CTRL bit map:
  - [0] EN, counter enable
  - [2:1] MODE; 2 and 3 behave as 0
  - [3] IM, interrupt mask-enable
  - [31:4] read as 0; writes to these bits are ignored
- PRESET: reload value, fully byte-writable.
- COUNT: read-only; writes are ignored.
- Register write: when `sel & we & byteen[i]`, byte i is merged at the clock edge.
- Any CTRL write (any byteen bit set) clears `irq_flag`.
- FSM states: IDLE, LOAD, CNT, INT. Reset state is IDLE.
- IDLE:
  - If EN = 1, go to LOAD.
- LOAD:
  - COUNT <= PRESET; go to CNT.
- CNT:
  - If EN = 0, go to IDLE; COUNT holds.
  - Else if COUNT > 1, COUNT <= COUNT − 1.
  - Else COUNT <= 0, `irq_flag` <= 1, go to INT.
- INT, mode 0: EN <= 0, go to IDLE; `irq_flag` stays set until a CTRL write.
- INT, mode 1: `irq_flag` <= 0, go to IDLE; because EN is still 1, the FSM reloads automatically.
- Simultaneous events:
  - A CPU CTRL write and an FSM EN-clear in the same cycle: the CPU write wins, including the value of EN.
  - A CTRL write and an `irq_flag` set in the same cycle: the flag set wins.
- A PRESET write during CNT does not affect the running count; it takes effect at the next LOAD.
- A PRESET of 0 behaves as 1 (terminal count reached on the first CNT cycle).
- COUNT arithmetic is unsigned 32-bit and never wraps below 0.
- Asserting `reset` mid-count returns the block immediately to its reset values, with no partial state retained.

## Timing
- Reset values:
  - CTRL = 0
  - PRESET = `PRESET_RST`
  - COUNT = 0
  - `irq_flag` = 0, `irq` = 0
  - state = IDLE
  - `rdata` = value of the register at `addr` (CTRL/COUNT 0)
- `rdata` has zero latency (combinational). The processor samples it in the M stage.
- Write latency: the register is updated at the same edge as the write cycle.
- Count sequence for PRESET = N ≥ 1, taking the write of EN = 1 at edge E0:
  - E1: state LOAD
  - E2: COUNT = N
  - E(2+k): COUNT = N − k
  - E(N+2): COUNT = 0, state INT, `irq` rises (if IM)
- One-shot latency from EN write to `irq` is N + 2 edges (3 edges when N = 0).
- Mode 1:
  - `irq` is high for exactly one cycle, from E(N+2) to E(N+3).
  - E(N+4): LOAD again.
  - Period is N + 3 cycles.
- Mode 0:
  - `irq` holds high until a CTRL write.
  - EN reads 0 from E(N+3).
- `irq` is glitch-free: a function of registered state only. It drops in the same cycle that IM is written to 0.

## Test plan
- Reset check: drive `reset` low mid-count with PRESET = 10 → all outputs return to reset values immediately; after release, the FSM stays in IDLE with COUNT = 0.
- One-shot: PRESET = 5, CTRL = 0x9 (EN, mode 0, IM) → COUNT reads 5, 4, 3, 2, 1 on successive cycles; `irq` = 1 at E7 and stays high; CTRL reads 0x8. Writing CTRL = 0x8 drops `irq` one edge later.
- Auto-reload: PRESET = 3, CTRL = 0xB (EN, mode 1, IM) → `irq` is a one-cycle pulse every 6 cycles; COUNT cycles 3, 2, 1, 0 continuously.
- Masking and pause: CTRL = 0x1 with PRESET = 4 → `irq` stays 0 while CTRL.IM = 0. Clearing EN mid-count freezes COUNT; re-enabling reloads from PRESET.
- Byte enables and read-only register:
  - PRESET write of 0xAABBCCDD with byteen = 4'b0101 over a prior value of 0 → PRESET reads 0x00BB00DD.
  - A write to COUNT or `addr` = 3 → no change.
  - A write with `sel` = 0 → ignored.
- Simultaneous event: CTRL write of 0x9 in the same cycle as the mode-0 INT→IDLE transition → EN reads 1, the FSM reloads, and the second countdown proceeds normally.

Source files
------------

// File: rtl/timer_unit.sv
// timer_unit
//   Memory-mapped 32-bit countdown timer for the processor data bus.
//   Three word registers: CTRL (EN, MODE, IM), PRESET (reload value) and
//   COUNT (read-only running count). A four-state FSM (IDLE, LOAD, CNT, INT)
//   loads PRESET, counts down to zero and raises an interrupt flag. Mode 1
//   reloads automatically; any other mode is one-shot and clears EN.
//
// Ports
//   clk     in   1   system clock, rising edge
//   reset   in   1   asynchronous, active-low reset
//   sel     in   1   chip select; writes ignored when low
//   addr    in   2   word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   we      in   1   write strobe (qualified by sel)
//   byteen  in   4   per-byte write enables
//   wdata   in   32  write data
//   rdata   out  32  combinational read of the register at addr
//   irq     out  1   interrupt request = CTRL.IM & irq_flag
module timer_unit #(
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t      state;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        wr_ctrl;
    logic        wr_ctrl_low;
    logic        wr_preset;
    logic        auto_reload;
    logic        flag_set;
    logic        flag_clr;
    logic        en_clr;

    // Per-byte merge of a bus write into an existing register value.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

    // Any byte lane counts as a CTRL write (it clears the flag), but only
    // lane 0 carries implemented bits.
    assign wr_ctrl     = sel && we && (addr == 2'd0) && (byteen != 4'b0000);
    assign wr_ctrl_low = wr_ctrl && byteen[0];
    assign wr_preset   = sel && we && (addr == 2'd1);

    assign auto_reload = (ctrl_mode == 2'b01);

    // Terminal count: covers COUNT = 1 and COUNT = 0 (PRESET of 0 acts as 1).
    assign flag_set = (state == S_CNT) && ctrl_en && (count <= 32'd1);
    assign flag_clr = wr_ctrl || ((state == S_INT) && auto_reload);
    assign en_clr   = (state == S_INT) && !auto_reload;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
            preset    <= PRESET_RST;
            count     <= 32'd0;
            irq_flag  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl_en) state <= S_LOAD;
                end
                S_LOAD: begin
                    count <= preset;
                    state <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_en) begin
                        state <= S_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count <= 32'd0;
                        state <= S_INT;
                    end
                end
                S_INT: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // CPU write takes priority over the FSM clearing EN.
            if (wr_ctrl_low) begin
                ctrl_en   <= wdata[0];
                ctrl_mode <= wdata[2:1];
                ctrl_im   <= wdata[3];
            end else if (en_clr) begin
                ctrl_en <= 1'b0;
            end

            // A terminal-count set beats any clear in the same cycle.
            if (flag_set) begin
                irq_flag <= 1'b1;
            end else if (flag_clr) begin
                irq_flag <= 1'b0;
            end

            if (wr_preset) begin
                preset <= merge_bytes(preset, wdata, byteen);
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0:    rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
            2'd1:    rdata = preset;
            2'd2:    rdata = count;
            default: rdata = 32'd0;
        endcase
    end

    assign irq = ctrl_im & irq_flag;

endmodule

// File: tb/tb_timer_unit.sv
module tb_timer_unit;

    logic        clk;
    logic        reset;
    logic        sel;
    logic [1:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    timer_unit #(.PRESET_RST(32'h0)) dut (
        .clk    (clk),
        .reset  (reset),
        .sel    (sel),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard of expected outputs, pushed when a read is set up and
    // popped once the DUT has settled.
    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        s;
        logic        w;
        logic [1:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [1:0]  ra;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    task automatic compare_front();
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (rdata !== e.rdata || irq !== e.irq) begin
            errors++;
            $display("FAIL %s: got rdata=%h irq=%b, want rdata=%h irq=%b",
                     e.name, rdata, irq, e.rdata, e.irq);
        end
    endtask

    task automatic expect_out(input string name, input logic [1:0] a,
                              input logic [31:0] r, input logic i);
        exp_t e;
        addr    = a;
        e.name  = name;
        e.rdata = r;
        e.irq   = i;
        sb.push_back(e);
        #1;
        compare_front();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic s, input logic w, input logic [1:0] a,
                       input logic [3:0] be, input logic [31:0] d);
        sel    = s;
        we     = w;
        addr   = a;
        byteen = be;
        wdata  = d;
        @(posedge clk);
        #1;
        sel    = 1'b0;
        we     = 1'b0;
        byteen = 4'b0000;
        wdata  = 32'd0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b1, 1'b1, a, 4'hF, d);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset  = 1'b0;
        sel    = 1'b0;
        we     = 1'b0;
        addr   = 2'd0;
        byteen = 4'b0000;
        wdata  = 32'd0;

        // ---------------- reset values ----------------
        #3;
        expect_out("rst_ctrl",   2'd0, 32'h0, 1'b0);
        expect_out("rst_preset", 2'd1, 32'h0, 1'b0);
        expect_out("rst_count",  2'd2, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ---------------- register access table ----------------
        vecs[0] = '{1'b1, 1'b1, 2'd1, 4'hF,    32'h0000_0000, 2'd1, 32'h0000_0000};
        vecs[1] = '{1'b1, 1'b1, 2'd1, 4'b0101, 32'hAABB_CCDD, 2'd1, 32'h00BB_00DD};
        vecs[2] = '{1'b1, 1'b1, 2'd2, 4'hF,    32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b1, 2'd3, 4'hF,    32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
        vecs[4] = '{1'b0, 1'b0, 2'd0, 4'h0,    32'h0000_0000, 2'd1, 32'h00BB_00DD};
        vecs[5] = '{1'b0, 1'b1, 2'd1, 4'hF,    32'h1234_5678, 2'd1, 32'h00BB_00DD};
        vecs[6] = '{1'b1, 1'b0, 2'd1, 4'hF,    32'h1234_5678, 2'd1, 32'h00BB_00DD};
        vecs[7] = '{1'b1, 1'b1, 2'd0, 4'hF,    32'hFFFF_FFF6, 2'd0, 32'h0000_0006};
        vecs[8] = '{1'b1, 1'b1, 2'd0, 4'b1110, 32'hFFFF_FFFF, 2'd0, 32'h0000_0006};
        vecs[9] = '{1'b1, 1'b1, 2'd1, 4'b1010, 32'h1122_3344, 2'd1, 32'h11BB_33DD};
        for (int i = 0; i < 10; i++) begin
            bus(vecs[i].s, vecs[i].w, vecs[i].a, vecs[i].be, vecs[i].d);
            expect_out($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp, 1'b0);
        end
        wr(2'd0, 32'h0);
        expect_out("ctrl_cleared", 2'd0, 32'h0, 1'b0);

        // ---------------- reset mid-count ----------------
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);            // E0
        tick(); tick(); tick(); tick();   // E4
        expect_out("pre_rst_count", 2'd2, 32'd8, 1'b0);
        #2;
        reset = 1'b0;
        expect_out("async_rst_count",  2'd2, 32'h0, 1'b0);
        expect_out("async_rst_ctrl",   2'd0, 32'h0, 1'b0);
        expect_out("async_rst_preset", 2'd1, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(); tick(); tick();
        expect_out("post_rst_count", 2'd2, 32'h0, 1'b0);
        expect_out("post_rst_ctrl",  2'd0, 32'h0, 1'b0);

        // ---------------- one-shot, PRESET = 5 ----------------
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);            // E0
        tick();                     // E1
        for (int k = 2; k <= 6; k++) begin
            tick();
            expect_out($sformatf("os_count_e%0d", k), 2'd2, 32'(7 - k), 1'b0);
        end
        tick();                     // E7
        expect_out("os_irq_e7", 2'd2, 32'd0, 1'b1);
        tick();                     // E8
        expect_out("os_ctrl_e8", 2'd0, 32'h8, 1'b1);
        tick(); tick();
        expect_out("os_irq_held", 2'd2, 32'd0, 1'b1);
        wr(2'd0, 32'h8);
        expect_out("os_irq_cleared", 2'd0, 32'h8, 1'b0);

        // ---------------- one-shot, PRESET = 0 ----------------
        do_reset();
        wr(2'd0, 32'h9);            // E0, PRESET still 0
        tick(); tick();             // E2
        expect_out("p0_e2", 2'd2, 32'd0, 1'b0);
        tick();                     // E3
        expect_out("p0_irq_e3", 2'd2, 32'd0, 1'b1);

        // ---------------- auto-reload, PRESET = 3 ----------------
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);            // E0
        for (int k = 1; k <= 18; k++) begin
            logic [31:0] ec;
            logic        ei;
            int          p;
            tick();
            ec = 32'd0;
            if (k >= 2) begin
                p = (k - 2) % 6;
                if (p <= 2) ec = 32'(3 - p);
            end
            ei = (k >= 5) && (((k - 5) % 6) == 0);
            expect_out($sformatf("ar_e%0d", k), 2'd2, ec, ei);
        end
        expect_out("ar_ctrl", 2'd0, 32'hB, 1'b0);

        // ---------------- masking and pause ----------------
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);            // E0
        tick(); tick();             // E2
        expect_out("mp_e2", 2'd2, 32'd4, 1'b0);
        tick();                     // E3
        expect_out("mp_e3", 2'd2, 32'd3, 1'b0);
        wr(2'd0, 32'h0);            // E4: last decrement while EN was 1
        expect_out("mp_e4", 2'd2, 32'd2, 1'b0);
        tick(); tick(); tick();
        expect_out("mp_frozen", 2'd2, 32'd2, 1'b0);
        wr(2'd0, 32'h1);            // F0
        tick(); tick();             // F2
        expect_out("mp_reload", 2'd2, 32'd4, 1'b0);
        tick(); tick(); tick(); tick();   // F6
        expect_out("mp_masked_irq", 2'd2, 32'd0, 1'b0);
        tick();                     // F7
        expect_out("mp_en_cleared", 2'd0, 32'h0, 1'b0);

        // ---------------- simultaneous events ----------------
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);            // E0
        tick(); tick();             // E2
        expect_out("sim_e2", 2'd2, 32'd2, 1'b0);
        tick(); tick();             // E4
        expect_out("sim_irq_e4", 2'd2, 32'd0, 1'b1);
        wr(2'd0, 32'h9);            // E5: CPU write during INT -> IDLE
        expect_out("sim_cpu_wins", 2'd0, 32'h9, 1'b0);
        tick(); tick();             // E7
        expect_out("sim_reload", 2'd2, 32'd2, 1'b0);
        tick();                     // E8
        expect_out("sim_e8", 2'd2, 32'd1, 1'b0);
        tick();                     // E9
        expect_out("sim_irq_e9", 2'd2, 32'd0, 1'b1);
        tick();                     // E10
        expect_out("sim_ctrl_e10", 2'd0, 32'h8, 1'b1);

        // CTRL write landing on the terminal-count edge: the flag set wins.
        wr(2'd0, 32'h9);            // G0 clears flag, EN = 1
        expect_out("fs_cleared", 2'd0, 32'h9, 1'b0);
        tick(); tick(); tick();     // G3
        expect_out("fs_g3", 2'd2, 32'd1, 1'b0);
        wr(2'd0, 32'h9);            // G4
        expect_out("fs_set_wins", 2'd2, 32'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
